// File: rtl/adc_sar_driver_pkg.sv
// Shared definitions for the SAR ADC driver: FSM state type, default
// geometry and small sizing helpers.
package adc_sar_driver_pkg;

  localparam int unsigned N_DEF            = 8;
  localparam int unsigned MAX_AVG_LOG2_DEF = 3;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;
  localparam int unsigned TIMEOUT_W_DEF    = 8;

  // Accumulator width and FIFO pointer width for the default configuration.
  localparam int unsigned ACC_W      = N_DEF + MAX_AVG_LOG2_DEF;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH_DEF);

  typedef enum logic [2:0] {
    IDLE,
    SOC,
    WAIT_BUSY,
    WAIT_DONE,
    ACCUM,
    PUSH
  } state_t;

  function automatic int unsigned acc_width(int unsigned n, int unsigned max_k);
    return n + max_k;
  endfunction

  function automatic int unsigned ptr_width(int unsigned depth);
    return $clog2(depth);
  endfunction

  // Clamp a requested averaging exponent to the supported maximum.
  function automatic int unsigned sat_k(int unsigned k, int unsigned max_k);
    return (k > max_k) ? max_k : k;
  endfunction

endpackage

// File: rtl/adc_sar_result_fifo.sv
// Small synchronous result FIFO. Simultaneous push and pop always succeed,
// including when full; a push into a full FIFO without a pop is discarded.
module adc_sar_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data
);
  import adc_sar_driver_pkg::*;

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             do_push;
  logic             do_pop;

  // Accept/refuse decisions and next occupancy.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  // Head of queue.
  always_comb begin
    data = mem[rd_ptr];
  end

  // Storage, pointers and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == (PTR_W+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/adc_sar_driver.sv
// SAR ADC driver master: issues soc pulses, tracks eoc with a timeout,
// averages 2^k conversions and queues results for the bus side.
module adc_sar_driver #(
  parameter int unsigned N            = 8,
  parameter int unsigned MAX_AVG_LOG2 = 3,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TIMEOUT_W    = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              start,
  input  logic                              continuous,
  input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] avg_log2,
  input  logic [TIMEOUT_W-1:0]              timeout,
  input  logic                              clear_err,
  output logic                              soc,
  input  logic                              eoc,
  input  logic                              eoa,
  input  logic [N-1:0]                      dout,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [N-1:0]                      res_data,
  output logic                              busy,
  output logic                              overflow,
  output logic                              timeout_err,
  output logic                              sampling
);
  import adc_sar_driver_pkg::*;

  localparam int unsigned KW        = $clog2(MAX_AVG_LOG2+1);
  localparam int unsigned ACC_WIDTH = acc_width(N, MAX_AVG_LOG2);
  localparam int unsigned CNT_W     = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;

  state_t                 state;
  logic [KW-1:0]          k_l;
  logic [KW-1:0]          k_sat;
  logic [TIMEOUT_W-1:0]   tmo_l;
  logic [TIMEOUT_W-1:0]   tcnt;
  logic [TIMEOUT_W-1:0]   tcnt_inc;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W:0]         cnt_last;
  logic                   pending;
  logic                   last_sample;
  logic                   wait_stall;
  logic                   tmo_event;
  logic [N-1:0]           result;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   drop;

  // Burst bookkeeping: sample-count terminal value, timeout hit, result.
  always_comb begin
    k_sat       = KW'(sat_k(32'(avg_log2), MAX_AVG_LOG2));
    cnt_last    = ((CNT_W+1)'(1) << k_l) - (CNT_W+1)'(1);
    last_sample = ({1'b0, cnt} == cnt_last);
    tcnt_inc    = tcnt + TIMEOUT_W'(1);
    wait_stall  = ((state == WAIT_BUSY) && eoc) || ((state == WAIT_DONE) && !eoc);
    tmo_event   = enable && wait_stall && (tmo_l != '0) && (tcnt_inc == tmo_l);
    result      = N'(acc >> k_l);
  end

  // FIFO handshake; an overflow is a push the FIFO cannot take this cycle.
  always_comb begin
    fifo_push = (state == PUSH) && enable;
    fifo_pop  = res_ready && res_valid;
    drop      = fifo_push && fifo_full && !fifo_pop;
    res_valid = !fifo_empty;
  end

  // Conversion sequencer; soc and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      soc     <= 1'b0;
      busy    <= 1'b0;
      pending <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      tcnt    <= '0;
      k_l     <= '0;
      tmo_l   <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      soc     <= 1'b0;
      busy    <= 1'b0;
      pending <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start || pending) begin
            if (eoc) begin
              state   <= SOC;
              soc     <= 1'b1;
              busy    <= 1'b1;
              pending <= 1'b0;
              k_l     <= k_sat;
              tmo_l   <= timeout;
            end else begin
              pending <= 1'b1;
            end
          end
        end
        SOC: begin
          state <= WAIT_BUSY;
          soc   <= 1'b0;
          tcnt  <= '0;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (!wait_stall) begin
            state <= (state == WAIT_BUSY) ? WAIT_DONE : ACCUM;
            tcnt  <= '0;
          end else if (tmo_event) begin
            state <= IDLE;
            busy  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_WIDTH'(dout);
          cnt <= cnt + CNT_W'(1);
          if (last_sample) begin
            state <= PUSH;
          end else begin
            state <= SOC;
            soc   <= 1'b1;
          end
        end
        PUSH: begin
          acc <= '0;
          cnt <= '0;
          if (continuous && eoc) begin
            state <= SOC;
            soc   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          soc   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
      if (tmo_event) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Acquisition-phase status for software.
  always_ff @(posedge clk) begin
    if (rst) begin
      sampling <= 1'b0;
    end else begin
      sampling <= (state != IDLE) && !eoa;
    end
  end

  adc_sar_result_fifo #(
    .WIDTH (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (result),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .data  (res_data)
  );

endmodule

// File: tb/tb_adc_sar_driver.sv
// Directed bench for adc_sar_driver with a simple behavioural SAR ADC model.
module tb_adc_sar_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] avg_log2 = 2'd0;
  logic [7:0] timeout = 8'd0;
  logic       clear_err = 1'b0;
  logic       soc;
  logic       eoc = 1'b1;
  logic       eoa = 1'b1;
  logic [7:0] dout = 8'd0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       busy;
  logic       overflow;
  logic       timeout_err;
  logic       sampling;

  int errors = 0;
  int checks = 0;

  // ADC model state
  logic [7:0] adc_vals [64];
  logic [5:0] adc_idx = 6'd0;
  logic       adc_hang = 1'b0;
  int         conv_cycles = 10;
  int         rem = 0;

  always #5 clk = ~clk;

  adc_sar_driver #(
    .N            (8),
    .MAX_AVG_LOG2 (3),
    .FIFO_DEPTH   (4),
    .TIMEOUT_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .start       (start),
    .continuous  (continuous),
    .avg_log2    (avg_log2),
    .timeout     (timeout),
    .clear_err   (clear_err),
    .soc         (soc),
    .eoc         (eoc),
    .eoa         (eoa),
    .dout        (dout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .sampling    (sampling)
  );

  // SAR ADC: accepts soc while idle, holds eoc low for conv_cycles, then
  // presents the next table value on dout as eoc returns high.
  always @(posedge clk) begin
    if (eoc) begin
      if (soc && !adc_hang) begin
        eoc <= 1'b0;
        rem <= conv_cycles - 1;
      end
    end else if (rem == 0) begin
      eoc     <= 1'b1;
      dout    <= adc_vals[adc_idx];
      adc_idx <= adc_idx + 6'd1;
    end else begin
      rem <= rem - 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_burst(input int bound, output int lat, output int socs);
    bit seen_busy;
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    socs = 0;
    seen_busy = 0;
    while (lat < bound) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (soc) socs++;
      if (busy) seen_busy = 1;
      else if (seen_busy) break;
    end
    start = 1'b0;
  endtask

  task automatic pop_one;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({soc, res_valid, busy, overflow, timeout_err, sampling} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {soc, res_valid, busy, overflow, timeout_err, sampling});
    end
    checks++;
    if (res_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h want 00", res_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int lat, socs;
    enable = 1'b1; avg_log2 = 2'd0; timeout = 8'd0; continuous = 1'b0;
    conv_cycles = 10;
    adc_vals[adc_idx] = 8'hA5;
    run_burst(300, lat, socs);
    // 2^0 * (3 + 10) + 2
    checks++;
    if (lat !== 15) begin errors++; $display("FAIL single_latency: got %0d want 15", lat); end
    checks++;
    if (socs !== 1) begin errors++; $display("FAIL single_soc_count: got %0d want 1", socs); end
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", res_valid); end
    checks++;
    if (res_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", res_data); end
    pop_one();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL single_pop_empty: got %b want 0", res_valid); end
  endtask

  task automatic test_average;
    int lat, socs;
    avg_log2 = 2'd2;
    adc_vals[adc_idx]        = 8'd10;
    adc_vals[adc_idx + 6'd1] = 8'd11;
    adc_vals[adc_idx + 6'd2] = 8'd12;
    adc_vals[adc_idx + 6'd3] = 8'd14;
    run_burst(400, lat, socs);
    // 4 * (3 + 10) + 2
    checks++;
    if (lat !== 54) begin errors++; $display("FAIL avg_latency: got %0d want 54", lat); end
    checks++;
    if (socs !== 4) begin errors++; $display("FAIL avg_soc_count: got %0d want 4", socs); end
    // (10+11+12+14) >> 2 = 47 >> 2 = 11
    checks++;
    if (res_data !== 8'h0B) begin errors++; $display("FAIL avg_data: got %h want 0b", res_data); end
    pop_one();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL avg_occupancy: got valid %b want 0 after one pop", res_valid); end
  endtask

  task automatic test_overflow;
    int n, drained;
    logic prev;
    logic [7:0] exp_last, first_pop, last_pop;
    avg_log2 = 2'd0; conv_cycles = 3; continuous = 1'b1; res_ready = 1'b0;
    for (int i = 0; i < 32; i++) adc_vals[adc_idx + 6'(i)] = 8'h20 + 8'(i);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!overflow && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    checks++;
    if (res_data !== 8'h20) begin errors++; $display("FAIL ovf_head: got %h want 20", res_data); end
    // find a conversion end, then pop exactly on the edge its result is pushed
    prev = eoc; n = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (eoc && !prev) break;
      prev = eoc;
    end
    exp_last = dout;
    clear_err = 1'b1;
    @(negedge clk);                 // ACCUM
    clear_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    @(negedge clk);                 // PUSH
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    enable = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_push_pop_full: got %b want 0", overflow); end
    @(negedge clk);
    continuous = 1'b0;
    drained = 0; first_pop = 8'h00; last_pop = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) begin
        if (drained == 0) first_pop = res_data;
        last_pop = res_data;
        drained++;
        pop_one();
      end
    end
    checks++;
    if (drained !== 4) begin errors++; $display("FAIL ovf_occupancy: got %0d want 4", drained); end
    checks++;
    if (first_pop !== 8'h21) begin errors++; $display("FAIL ovf_first: got %h want 21", first_pop); end
    checks++;
    if (last_pop !== exp_last) begin errors++; $display("FAIL ovf_last: got %h want %h", last_pop, exp_last); end
    enable = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_timeout;
    int n, socs;
    adc_hang = 1'b1; timeout = 8'd20; continuous = 1'b1; avg_log2 = 2'd0;
    @(negedge clk); start = 1'b1;
    n = 0;
    while (!soc && n < 20) begin @(negedge clk); n++; start = 1'b0; end
    start = 1'b0;
    @(negedge clk);                 // WAIT_BUSY entered on this edge
    eoa = 1'b0;
    n = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (n == 2) begin
        checks++;
        if (sampling !== 1'b1) begin errors++; $display("FAIL tmo_sampling: got %b want 1", sampling); end
      end
      if (timeout_err) break;
    end
    eoa = 1'b1;
    checks++;
    if (n !== 20) begin errors++; $display("FAIL tmo_cycles: got %0d want 20", n); end
    checks++;
    if ({busy, res_valid, soc} !== 3'b000) begin
      errors++; $display("FAIL tmo_idle: got busy/valid/soc %b want 000", {busy, res_valid, soc});
    end
    socs = 0;
    repeat (30) begin @(negedge clk); if (soc) socs++; end
    checks++;
    if (socs !== 0) begin errors++; $display("FAIL tmo_no_restart: got %0d soc want 0", socs); end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", timeout_err); end
    adc_hang = 1'b0; timeout = 8'd0; continuous = 1'b0;
  endtask

  task automatic test_enable_drop;
    int lat, socs, falls, n;
    logic prev;
    avg_log2 = 2'd0; conv_cycles = 10;
    adc_vals[adc_idx] = 8'h5A;
    run_burst(300, lat, socs);
    avg_log2 = 2'd2;
    for (int i = 0; i < 4; i++) adc_vals[adc_idx + 6'(i)] = 8'h40;
    @(negedge clk); start = 1'b1;
    prev = eoc; falls = 0; n = 0;
    while (falls < 2 && n < 200) begin
      @(negedge clk); n++; start = 1'b0;
      if (!eoc && prev) falls++;
      prev = eoc;
    end
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, soc} !== 2'b00) begin errors++; $display("FAIL en_idle: got busy/soc %b want 00", {busy, soc}); end
    socs = 0;
    repeat (60) begin @(negedge clk); if (soc) socs++; end
    checks++;
    if (socs !== 0) begin errors++; $display("FAIL en_no_soc: got %0d want 0", socs); end
    checks++;
    if (res_data !== 8'h5A || res_valid !== 1'b1) begin
      errors++; $display("FAIL en_fifo_kept: got valid %b data %h want 1 5a", res_valid, res_data);
    end
    pop_one();
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL en_no_result: got %b want 0", res_valid); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid;
    int lat, socs, falls, n;
    logic prev, eoc_at_soc, saw;
    avg_log2 = 2'd0;
    adc_vals[adc_idx] = 8'h31;
    adc_vals[adc_idx + 6'd1] = 8'h32;
    run_burst(300, lat, socs);
    run_burst(300, lat, socs);
    avg_log2 = 2'd2;
    @(negedge clk); start = 1'b1;
    prev = eoc; falls = 0; n = 0;
    while (falls < 2 && n < 200) begin
      @(negedge clk); n++; start = 1'b0;
      if (!eoc && prev) falls++;
      prev = eoc;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({soc, res_valid, busy, overflow, timeout_err, sampling} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_flags: got %b want 000000",
                         {soc, res_valid, busy, overflow, timeout_err, sampling});
    end
    checks++;
    if (res_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", res_data); end
    rst = 1'b0;
    avg_log2 = 2'd0;
    // ADC still converting: a new start must wait for eoc
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({soc, busy} !== 2'b00) begin errors++; $display("FAIL rst_pending_wait: got soc/busy %b want 00", {soc, busy}); end
    saw = 1'b0; eoc_at_soc = 1'b0; n = 0;
    while (!saw && n < 50) begin
      @(negedge clk); n++;
      if (soc) begin saw = 1'b1; eoc_at_soc = eoc; end
    end
    checks++;
    if ({saw, eoc_at_soc} !== 2'b11) begin
      errors++; $display("FAIL rst_pending_soc: got seen/eoc %b want 11", {saw, eoc_at_soc});
    end
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL rst_pending_result: got %b want 1", res_valid); end
    pop_one();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) adc_vals[i] = 8'h00;
    test_reset();
    test_single();
    test_average();
    test_overflow();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_sar_driver.md
Name: adc_sar_driver

Overview:
- Digital master for the SAR ADC controller's driver interface (soc/eoc/eoa/dout).
- Issues start-of-conversion pulses and tracks conversion progress with a timeout.
- Averages 2^k conversions per result and pushes results into a small result FIFO for the register/bus side.
- Sits between the ADC controller and the system bus slave, in the same clock domain as the ADC controller.

Parameters:
- N, 8, ADC result width (matches ADC controller N).
- MAX_AVG_LOG2, 3, max averaging exponent; the accumulator is N+MAX_AVG_LOG2 bits.
- FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).
- TIMEOUT_W, 8, timeout counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  block enable; low aborts any conversion.
- start  in  1  single-cycle request for one averaged result.
- continuous  in  1  1: restart automatically after each result while enable=1.
- avg_log2  in  $clog2(MAX_AVG_LOG2+1)  averaging exponent k; values >MAX_AVG_LOG2 saturate to MAX_AVG_LOG2.
- timeout  in  TIMEOUT_W  max cycles per wait phase; 0 disables the timeout.
- clear_err  in  1  clears the sticky flags.
- soc  out  1  start-of-conversion to the ADC.
- eoc  in  1  ADC idle/end of conversion (high = idle).
- eoa  in  1  ADC end of acquisition; status only.
- dout  in  N  ADC result, valid while eoc=1 after a conversion.
- res_valid  out  1  FIFO not empty.
- res_ready  in  1  pop when res_valid=1.
- res_data  out  N  FIFO head.
- busy  out  1  FSM not in IDLE.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- timeout_err  out  1  sticky: a wait phase timed out.
- sampling  out  1  registered ~eoa while busy.

Behaviour:
- Reset: FSM=IDLE, soc=0, accumulator=0, sample counter=0, FIFO empty (res_valid=0, res_data=0), busy=0, overflow=0, timeout_err=0, sampling=0.
- All outputs are registered.
- FSM states: IDLE, SOC, WAIT_BUSY, WAIT_DONE, ACCUM, PUSH.
- IDLE -> SOC when enable & start & eoc. A start arriving while eoc=0 is held pending until eoc=1; start while busy is ignored.
- SOC: soc=1 for exactly one cycle -> WAIT_BUSY.
- WAIT_BUSY: wait for eoc=0 -> WAIT_DONE.
- WAIT_DONE: wait for eoc=1 -> ACCUM.
- ACCUM (1 cycle):
  - acc += dout (zero-extended); cnt++.
  - If cnt == 2^k - 1 before the increment -> PUSH, else -> SOC.
- PUSH (1 cycle):
  - result = acc >> k (truncating; k=0 gives the raw value).
  - Write result to the FIFO; acc and cnt cleared.
  - Next state: SOC if enable & continuous & eoc, else IDLE.
- Latency from start to res_valid with an ideal ADC is 2^k * (3 + conv_cycles) + 2 cycles, where conv_cycles = cycles with eoc=0.
- Timeout:
  - The counter resets on entry to WAIT_BUSY and WAIT_DONE and increments each cycle in those states.
  - When timeout != 0 and counter == timeout: timeout_err=1, acc/cnt cleared, -> IDLE; continuous does not restart.
- enable=0 in any state: next cycle FSM=IDLE, soc=0, acc/cnt cleared. FIFO contents and sticky flags are kept.
- FIFO:
  - Push and pop in the same cycle both succeed, including when full (pop frees the slot first).
  - Push when full without a pop: data dropped, overflow=1.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter distinguishes full from empty.
- Sticky flags: clear_err clears them; a set event in the same cycle as clear_err wins (flag stays 1).
- rst mid-conversion: immediate return to reset values. The ADC may still be converting; the next start waits for eoc=1.
- avg_log2 and timeout are sampled at IDLE->SOC and held for the whole burst.

Decomposition:
- Package adc_sar_driver_pkg holds the state encoding localparams, ACC_W = N+MAX_AVG_LOG2, and the FIFO pointer width.
- Sub-module adc_sar_result_fifo (synchronous FIFO, parameters WIDTH/DEPTH, ports push/pop/full/empty/data) is instantiated once.

Test Plan:
- k=0, ADC model returns 0xA5 after 10 eoc-low cycles; pulse start -> one soc pulse, res_valid=1 after 15 cycles, res_data=0xA5, busy returns to 0.
- k=2, ADC returns 10, 11, 12, 14 -> 4 soc pulses, single result 0x0B (47>>2), FIFO occupancy 1.
- continuous=1, res_ready=0, FIFO_DEPTH=4 -> 4 results stored, 5th dropped, overflow=1; pop one with a push in the same cycle -> no further overflow, occupancy stays 4.
- ADC holds eoc=1 after soc, timeout=20 -> timeout_err=1 exactly 20 cycles after WAIT_BUSY entry, FSM=IDLE, no FIFO write; clear_err -> 0.
- enable dropped during WAIT_DONE of the 2nd of 4 samples -> IDLE next cycle, soc never reasserted, no result, prior FIFO data intact.
- rst asserted mid-burst with FIFO holding 2 entries -> next cycle all outputs at reset values, res_valid=0.
